// File: rtl/disp_pkg.sv
// disp_pkg: shared constants and colour helpers for the display output stage
package disp_pkg;
  localparam logic [0:3][0:3][3:0] BAYER4 = {
    4'd0,  4'd8,  4'd2,  4'd10,
    4'd12, 4'd4,  4'd14, 4'd6,
    4'd3,  4'd11, 4'd1,  4'd9,
    4'd15, 4'd7,  4'd13, 4'd5
  };
  function automatic logic [11:0] colr_expand(input logic [11:0] c, input int bin, input int bout);
    colr_expand = '0;
    for (int i = 0; i < 12; i++)
      if (i < bout) colr_expand[i] = c[bin - 1 - ((bout - 1 - i) % bin)];
  endfunction
  function automatic logic [12:0] colr_sat_add(input logic [12:0] a, input logic [12:0] b, input int bin);
    logic [12:0] lim;
    logic [12:0] sum;
    lim = 13'((1 << bin) - 1);
    sum = a + b;
    return sum > lim ? lim : sum;
  endfunction
endpackage

// File: rtl/disp_delay.sv
// disp_delay: width x depth register chain, async active-low reset to 0 (depth 0 is a wire)
module disp_delay #(
  parameter int W = 8,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  if (DEPTH == 0) begin : g_wire
    assign q = d;
  end else begin : g_regs
    logic [W-1:0] pipe [DEPTH];
    // shift the bundle one stage per clock
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
      end else begin
        pipe[0] <= d;
        for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
      end
    assign q = pipe[DEPTH-1];
  end
endmodule

// File: rtl/disp_colr_adapt.sv
// disp_colr_adapt: pipelined RGB width adapter with blanking; ordered dither under DISP_COLR_DITHER_EN
module disp_colr_adapt
  import disp_pkg::*;
#(
  parameter int BPC_IN  = 5,
  parameter int BPC_OUT = 8,
  parameter int CORDW   = 16,
  parameter int PIPE    = 2
) (
  input  logic                    clk_pix,
  input  logic                    rst_pix_n,
  input  logic signed [CORDW-1:0] in_x,
  input  logic signed [CORDW-1:0] in_y,
  input  logic                    in_hsync,
  input  logic                    in_vsync,
  input  logic                    in_de,
  input  logic                    in_frame,
  input  logic [BPC_IN-1:0]       in_r,
  input  logic [BPC_IN-1:0]       in_g,
  input  logic [BPC_IN-1:0]       in_b,
  output logic signed [CORDW-1:0] out_x,
  output logic signed [CORDW-1:0] out_y,
  output logic                    out_hsync,
  output logic                    out_vsync,
  output logic                    out_de,
  output logic                    out_frame,
  output logic [BPC_OUT-1:0]      out_r,
  output logic [BPC_OUT-1:0]      out_g,
  output logic [BPC_OUT-1:0]      out_b
);
  localparam int D   = BPC_IN > BPC_OUT ? BPC_IN - BPC_OUT : 0;
  localparam int SHR = D <= 4 ? 4 - D : 0;
  localparam int SHL = D > 4 ? D - 4 : 0;
  localparam int W   = 2 * CORDW + 4 + 3 * BPC_OUT;
  logic [3:0] thr;
`ifdef DISP_COLR_DITHER_EN
  logic [1:0] frame_cnt;
  logic [1:0] row;
  logic [1:0] col;
  // frame counter steps after each frame-start pixel, rotating the dither pattern
  always_ff @(posedge clk_pix or negedge rst_pix_n)
    if (!rst_pix_n) frame_cnt <= '0;
    else if (in_frame) frame_cnt <= frame_cnt + 2'd1;
  assign row = in_y[1:0] + frame_cnt;
  assign col = in_x[1:0] + frame_cnt;
  assign thr = BAYER4[row][col];
`else
  assign thr = 4'd0;
`endif
  function automatic logic [BPC_OUT-1:0] conv(input logic [BPC_IN-1:0] c, input logic [3:0] t);
    logic [11:0] e;
    logic [12:0] s;
    e = colr_expand(12'(c), BPC_IN, BPC_OUT);
    s = D <= 4 ? 13'(t) >> SHR : 13'(t) << SHL;
    if (BPC_OUT >= BPC_IN) return e[BPC_OUT-1:0];
`ifdef DISP_COLR_DITHER_EN
    return BPC_OUT'(colr_sat_add(13'(c), s, BPC_IN) >> D);
`else
    return BPC_OUT'(13'(c) >> D);
`endif
  endfunction
  logic [BPC_OUT-1:0] r1, g1, b1;
  logic [W-1:0] s1, q;
  // stage-1 colour conversion, blanked outside the active area
  always_comb begin
    r1 = in_de ? conv(in_r, thr) : '0;
    g1 = in_de ? conv(in_g, thr) : '0;
    b1 = in_de ? conv(in_b, thr) : '0;
  end
  // stage-1 register captures converted colour alongside timing and position
  always_ff @(posedge clk_pix or negedge rst_pix_n)
    if (!rst_pix_n) s1 <= '0;
    else s1 <= {in_x, in_y, in_hsync, in_vsync, in_de, in_frame, r1, g1, b1};
  disp_delay #(.W(W), .DEPTH(PIPE - 1)) u_delay (
    .clk   (clk_pix),
    .rst_n (rst_pix_n),
    .d     (s1),
    .q     (q)
  );
  assign {out_x, out_y, out_hsync, out_vsync, out_de, out_frame, out_r, out_g, out_b} = q;
endmodule

// File: tb/tb_disp_colr_adapt.sv
// tb_disp_colr_adapt: directed checks of a 5->8 (PIPE 2) and an 8->5 (PIPE 3) instance
module tb_disp_colr_adapt;
  logic clk = 0, rst_n = 0;
  logic signed [15:0] x = 0, y = 0;
  logic hs = 0, vs = 0, de = 0, fr = 0;
  logic [4:0] ar = 0, ag = 0, ab = 0;
  logic [7:0] br = 0, bg = 0, bb = 0;
  logic signed [15:0] a_x, a_y, b_x, b_y;
  logic a_hs, a_vs, a_de, a_fr, b_hs, b_vs, b_de, b_fr;
  logic [7:0] a_r, a_g, a_b;
  logic [4:0] b_r, b_g, b_b;
  int n_cmp = 0, n_err = 0;
  logic [4:0] va [4] = '{5'h1F, 5'h10, 5'h01, 5'h00};
  logic [7:0] ea [4] = '{8'hFF, 8'h84, 8'h08, 8'h00};
  logic [7:0] vb [4] = '{8'hFF, 8'h84, 8'h07, 8'h00};
  logic [4:0] eb [4] = '{5'h1F, 5'h10, 5'h00, 5'h00};
  always #5 clk = ~clk;
  disp_colr_adapt #(.BPC_IN(5), .BPC_OUT(8), .CORDW(16), .PIPE(2)) dut_a (
    .clk_pix(clk), .rst_pix_n(rst_n), .in_x(x), .in_y(y), .in_hsync(hs), .in_vsync(vs),
    .in_de(de), .in_frame(fr), .in_r(ar), .in_g(ag), .in_b(ab),
    .out_x(a_x), .out_y(a_y), .out_hsync(a_hs), .out_vsync(a_vs), .out_de(a_de),
    .out_frame(a_fr), .out_r(a_r), .out_g(a_g), .out_b(a_b));
  disp_colr_adapt #(.BPC_IN(8), .BPC_OUT(5), .CORDW(16), .PIPE(3)) dut_b (
    .clk_pix(clk), .rst_pix_n(rst_n), .in_x(x), .in_y(y), .in_hsync(hs), .in_vsync(vs),
    .in_de(de), .in_frame(fr), .in_r(br), .in_g(bg), .in_b(bb),
    .out_x(b_x), .out_y(b_y), .out_hsync(b_hs), .out_vsync(b_vs), .out_de(b_de),
    .out_frame(b_fr), .out_r(b_r), .out_g(b_g), .out_b(b_b));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    #1;
    de = 1; x = 5; ar = 5'h1F; br = 8'hFF; fr = 1;
    tick(1);
    chk("rst_a_r", a_r, 0);
    chk("rst_b_r", b_r, 0);
    chk("rst_b_x", {16'h0, b_x}, 0);
    chk("rst_a_de", a_de, 0);
    chk("rst_b_fr", b_fr, 0);
    fr = 0; x = 0;
    #2 rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      ar = va[i]; ag = va[i]; ab = va[i];
      br = vb[i]; bg = vb[i]; bb = vb[i];
      tick(3);
      chk("exp_r", a_r, ea[i]);
      chk("exp_g", a_g, ea[i]);
      chk("exp_b", a_b, ea[i]);
      chk("red_r", b_r, eb[i]);
      chk("red_g", b_g, eb[i]);
      chk("red_b", b_b, eb[i]);
    end
`ifdef DISP_COLR_DITHER_EN
    br = 8'h04; y = 3;
    tick(3);
    chk("dith_y3", b_r, 5'h01);
    br = 8'hFC;
    tick(3);
    chk("dith_sat", b_r, 5'h1F);
    y = 0;
`endif
    fr = 1; x = 7;
    tick(1);
    fr = 0; x = 8;
    chk("lat_b_e0", b_fr, 0);
    chk("lat_a_e0", a_fr, 0);
    tick(1);
    chk("lat_b_e1", b_fr, 0);
    chk("lat_a_e1", a_fr, 1);
    chk("lat_a_x", {16'h0, a_x}, 7);
    tick(1);
    chk("lat_b_e2", b_fr, 1);
    chk("lat_b_x", {16'h0, b_x}, 7);
    chk("lat_b_de", b_de, 1);
    tick(1);
    chk("lat_b_e3", b_fr, 0);
    chk("lat_b_x3", {16'h0, b_x}, 8);
`ifdef DISP_COLR_DITHER_EN
    br = 8'h01; x = 3; y = 2;
    tick(3);
    chk("dith_fcnt1", b_r, 5'h01);
`endif
    de = 0; hs = 1; vs = 1; x = -16; y = -3;
    ar = 5'h1F; ag = 5'h1F; ab = 5'h1F; br = 8'hFF; bg = 8'hFF; bb = 8'hFF;
    tick(3);
    chk("blk_a_r", a_r, 0);
    chk("blk_a_g", a_g, 0);
    chk("blk_a_b", a_b, 0);
    chk("blk_b_r", b_r, 0);
    chk("blk_b_g", b_g, 0);
    chk("blk_b_b", b_b, 0);
    chk("blk_b_x", {16'h0, b_x}, 32'h0000FFF0);
    chk("blk_b_y", {16'h0, b_y}, 32'h0000FFFD);
    chk("blk_a_x", {16'h0, a_x}, 32'h0000FFF0);
    chk("blk_b_hs", b_hs, 1);
    chk("blk_b_vs", b_vs, 1);
    chk("blk_b_de", b_de, 0);
    de = 1; hs = 0; vs = 0; x = 9; y = 2;
    tick(3);
    chk("pre_rst_b_r", b_r, 5'h1F);
    #2 rst_n = 0;
    #1;
    chk("arst_a_r", a_r, 0);
    chk("arst_b_r", b_r, 0);
    chk("arst_b_x", {16'h0, b_x}, 0);
    chk("arst_a_de", a_de, 0);
    #2 rst_n = 1;
    tick(1);
    chk("rel_b_r_e1", b_r, 0);
    chk("rel_b_de_e1", b_de, 0);
    tick(1);
    chk("rel_b_r_e2", b_r, 0);
    chk("rel_a_r_e2", a_r, 8'hFF);
    tick(1);
    chk("rel_b_r_e3", b_r, 5'h1F);
    chk("rel_b_x_e3", {16'h0, b_x}, 9);
`ifdef DISP_COLR_DITHER_EN
    br = 8'h05; x = 0; y = 2;
    tick(3);
    chk("fcnt_restart", b_r, 5'h00);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
